// File: rtl/countere_pkg.sv
// Shared definitions for the clock/timer block: mode codes, FSM states, ROM entry layout.
package countere_pkg;

  localparam int unsigned MODE_W  = 3;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  localparam logic [MODE_W-1:0] MODE_MENU  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_CLOCK = 3'b001;
  localparam logic [MODE_W-1:0] MODE_TIMER = 3'b010;
  localparam logic [MODE_W-1:0] MODE_STOPW = 3'b011;

  typedef enum logic [1:0] {IDLE, CLOCK, TIMER, STOPW} state_t;

  // One ROM word: legality flag plus the mode it selects.
  typedef struct packed {
    logic              legal;
    logic [MODE_W-1:0] mode;
  } rom_entry_t;

  // Map an accepted mode code onto the FSM state that runs it.
  function automatic state_t mode_to_state(input logic [MODE_W-1:0] m);
    case (m)
      MODE_CLOCK: return CLOCK;
      MODE_TIMER: return TIMER;
      MODE_STOPW: return STOPW;
      default:    return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/countere_fsm_rom_if.sv
// User-side bus of the clock/timer block.
//   master: drives optiune_user, validare_fsm, switch; observes valid, fsm_reset, optiune, cnt_min, cnt_sec
//   slave : the block itself
interface countere_fsm_rom_if;
  import countere_pkg::*;

  logic [MODE_W-1:0] optiune_user;
  logic              validare_fsm;
  logic              switch;
  logic              valid;
  logic              fsm_reset;
  logic [MODE_W-1:0] optiune;
  logic [CNT_W-1:0]  cnt_min;
  logic [CNT_W-1:0]  cnt_sec;

  modport master (
    output optiune_user, validare_fsm, switch,
    input  valid, fsm_reset, optiune, cnt_min, cnt_sec
  );

  modport slave (
    input  optiune_user, validare_fsm, switch,
    output valid, fsm_reset, optiune, cnt_min, cnt_sec
  );
endinterface

// File: rtl/countere_fsm_rom_option_rom.sv
// Mode legality ROM, 8 x {legal, mode}, purely combinational.
//   code    : mode code to look up
//   entry_c : ROM word for that code
module option_rom
  import countere_pkg::*;
(
  input  logic [MODE_W-1:0] code,
  output rom_entry_t        entry_c
);

  always_comb begin
    entry_c = '{legal: 1'b0, mode: MODE_MENU};
    case (code)
      3'b000:  entry_c = '{legal: 1'b1, mode: MODE_MENU};
      3'b001:  entry_c = '{legal: 1'b1, mode: MODE_CLOCK};
      3'b010:  entry_c = '{legal: 1'b1, mode: MODE_TIMER};
      3'b011:  entry_c = '{legal: 1'b1, mode: MODE_STOPW};
      default: entry_c = '{legal: 1'b0, mode: MODE_MENU};
    endcase
  end

endmodule

// File: rtl/countere_fsm_rom.sv
// Clock/timer block top: validate synchroniser, mode FSM, tick prescaler, mm:ss counter.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : user bus (mode select/validate/run in; legality, armed mode, mm:ss out)
module countere_fsm_rom_top
  import countere_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned TIMER_PRESET = 300
) (
  input  logic                clk,
  input  logic                rst,
  countere_fsm_rom_if.slave   bus
);

  localparam int unsigned      PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_MIN  = CNT_W'(TIMER_PRESET / 60);
  localparam logic [CNT_W-1:0] PRE_SEC  = CNT_W'(TIMER_PRESET % 60);
  localparam logic [CNT_W-1:0] SEC_TC   = CNT_W'(SEC_MAX);
  localparam logic [CNT_W-1:0] MIN_TC   = CNT_W'(MIN_MAX);

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   optiune_q, optiune_d;
  logic [CNT_W-1:0]    min_q, min_d, sec_q, sec_d;
  logic                fsm_reset_q, fsm_reset_d;
  logic                valid_q;
  logic [2:0]          val_sync_q;
  logic [PRESC_W-1:0]  presc_q;
  rom_entry_t          rom_c;
  logic                val_c, accept_c, run_c, tick_c;

  option_rom u_rom (
    .code    (bus.optiune_user),
    .entry_c (rom_c)
  );

  // Two-stage synchroniser plus one history bit for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) val_sync_q <= 3'b111;
    else      val_sync_q <= {val_sync_q[1:0], bus.validare_fsm};
  end

  assign val_c    = val_sync_q[2] & ~val_sync_q[1];
  assign accept_c = val_c & ~bus.switch & rom_c.legal;
  assign run_c    = bus.switch & (state_q != IDLE);
  assign tick_c   = run_c & (presc_q == PRESC_TC);

  // Seconds prescaler; cleared whenever the block is back in configure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              presc_q <= '0;
    else if (!bus.switch)  presc_q <= '0;
    else if (run_c)        presc_q <= tick_c ? '0 : presc_q + PRESC_W'(1);
  end

  // Registered legality of whatever code is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= 1'b0;
    else      valid_q <= rom_c.legal;
  end

  // FSM and counter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      optiune_q   <= MODE_MENU;
      min_q       <= '0;
      sec_q       <= '0;
      fsm_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      optiune_q   <= optiune_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      fsm_reset_q <= fsm_reset_d;
    end
  end

  // Next state: accept (configure only) and tick (run only) are mutually exclusive.
  always_comb begin
    state_d     = state_q;
    optiune_d   = optiune_q;
    min_d       = min_q;
    sec_d       = sec_q;
    fsm_reset_d = 1'b0;

    if (accept_c) begin
      optiune_d   = rom_c.mode;
      state_d     = mode_to_state(rom_c.mode);
      fsm_reset_d = (rom_c.mode == MODE_MENU);
      if (rom_c.mode == MODE_TIMER) begin
        min_d = PRE_MIN;
        sec_d = PRE_SEC;
      end else begin
        min_d = '0;
        sec_d = '0;
      end
    end else if (tick_c) begin
      case (state_q)
        CLOCK: begin
          if (sec_q == SEC_TC) begin
            sec_d = '0;
            min_d = (min_q == MIN_TC) ? '0 : min_q + CNT_W'(1);
          end else begin
            sec_d = sec_q + CNT_W'(1);
          end
        end
        STOPW: begin
          if (!(min_q == MIN_TC && sec_q == SEC_TC)) begin
            if (sec_q == SEC_TC) begin
              sec_d = '0;
              min_d = min_q + CNT_W'(1);
            end else begin
              sec_d = sec_q + CNT_W'(1);
            end
          end
        end
        TIMER: begin
          if (sec_q != '0) begin
            sec_d = sec_q - CNT_W'(1);
          end else if (min_q != '0) begin
            sec_d = SEC_TC;
            min_d = min_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.valid     = valid_q;
  assign bus.fsm_reset = fsm_reset_q;
  assign bus.optiune   = optiune_q;
  assign bus.cnt_min   = min_q;
  assign bus.cnt_sec   = sec_q;

endmodule

// File: tb/tb_countere_fsm_rom_top.sv
// Scoreboard bench for countere_fsm_rom_top (TICK_DIV=1, TIMER_PRESET=300).
module tb_countere_fsm_rom_top;

  typedef enum int {S_VALID, S_FSMRST, S_OPT, S_MIN, S_SEC} sig_e;
  typedef struct {
    string       tag;
    sig_e        sel;
    int unsigned val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  exp_t sb[$];

  countere_fsm_rom_if bus_if ();

  countere_fsm_rom_top #(.TICK_DIV(1), .TIMER_PRESET(300)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_if.fsm_reset === 1'b1) n_pulses++;

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned observe(input sig_e s);
    case (s)
      S_VALID:  return 32'(bus_if.valid);
      S_FSMRST: return 32'(bus_if.fsm_reset);
      S_OPT:    return 32'(bus_if.optiune);
      S_MIN:    return 32'(bus_if.cnt_min);
      default:  return 32'(bus_if.cnt_sec);
    endcase
  endfunction

  task automatic push(input string tag, input sig_e sel, input int unsigned v);
    sb.push_back('{tag: tag, sel: sel, val: v});
  endtask

  task automatic push_cnt(input string tag, input int unsigned secs);
    push({tag, ".min"}, S_MIN, secs / 60);
    push({tag, ".sec"}, S_SEC, secs % 60);
  endtask

  // Pop every pending expectation and compare against the DUT as it is now.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Validate pulse falls at a negedge; accept lands on the third rising edge.
  task automatic validate_low();
    bus_if.validare_fsm = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic validate_release();
    bus_if.validare_fsm = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned t;
    bus_if.optiune_user = 3'b000;
    bus_if.validare_fsm = 1'b1;
    bus_if.switch       = 1'b0;

    // 1: reset values, then valid follows code 000 one clock after release
    #95;
    push("rst.valid", S_VALID, 0);
    push("rst.opt", S_OPT, 0);
    push_cnt("rst.cnt", 0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push("post_rst.valid", S_VALID, 1);
    push("post_rst.fsm_reset", S_FSMRST, 0);
    push("post_rst.opt", S_OPT, 0);
    push_cnt("post_rst.cnt", 0);
    drain();

    // 2: code 001 accepted once despite a long validate hold
    bus_if.optiune_user = 3'b001;
    push("clk_arm.opt", S_OPT, 1);
    push_cnt("clk_arm.cnt", 0);
    push("clk_arm.fsm_reset", S_FSMRST, 0);
    validate_low();
    drain();
    bus_if.optiune_user = 3'b000;
    repeat (197) @(negedge clk);
    validate_release();
    push("hold.opt", S_OPT, 1);
    drain();
    check_eq("hold.pulses", 32'(n_pulses), 0);

    // 3: code 000 gives a single-clock fsm_reset and returns to menu
    push("menu.fsm_reset", S_FSMRST, 1);
    push("menu.opt", S_OPT, 0);
    validate_low();
    drain();
    @(negedge clk);
    push("menu.fsm_reset_end", S_FSMRST, 0);
    drain();
    validate_release();
    check_eq("menu.pulses", 32'(n_pulses), 1);

    // 4: code sweep without validate changes only valid
    for (int i = 0; i < 4; i++) begin
      logic [2:0] codes [4] = '{3'b011, 3'b100, 3'b110, 3'b010};
      bus_if.optiune_user = codes[i];
      push($sformatf("sweep%0d.valid", i), S_VALID, (codes[i] < 3'b100) ? 1 : 0);
      push($sformatf("sweep%0d.opt", i), S_OPT, 0);
      @(negedge clk);
      drain();
    end
    // illegal code with validate is ignored
    bus_if.optiune_user = 3'b101;
    validate_low();
    push("illegal.opt", S_OPT, 0);
    drain();
    validate_release();

    // 5: timer countdown from 05:00, holds at 00:00, run-time validate ignored
    bus_if.optiune_user = 3'b010;
    validate_low();
    push("timer_arm.opt", S_OPT, 2);
    push_cnt("timer_arm.cnt", 300);
    drain();
    validate_release();
    bus_if.switch = 1'b1;
    t = 300;
    for (int c = 0; c < 310; c++) begin
      if (c == 20) begin
        bus_if.optiune_user = 3'b001;
        bus_if.validare_fsm = 1'b0;
      end
      if (c == 40) bus_if.validare_fsm = 1'b1;
      @(negedge clk);
      t = (t > 0) ? t - 1 : 0;
      push_cnt($sformatf("timer%0d", c), t);
      drain();
    end
    push("timer_end.opt", S_OPT, 2);
    drain();

    // 6a: clock mode from 00:00 through 59:58, 59:59, wrap to 00:00
    bus_if.switch = 1'b0;
    @(negedge clk);
    bus_if.optiune_user = 3'b001;
    validate_low();
    push("clock_arm.opt", S_OPT, 1);
    push_cnt("clock_arm.cnt", 0);
    drain();
    validate_release();
    bus_if.switch = 1'b1;
    t = 0;
    for (int c = 0; c < 3603; c++) begin
      @(negedge clk);
      t = (t + 1) % 3600;
      push_cnt($sformatf("clock%0d", c), t);
      drain();
    end
    // freeze on switch drop
    bus_if.switch = 1'b0;
    repeat (3) @(negedge clk);
    push_cnt("freeze", t);
    drain();

    // 6b: stopwatch saturates at 59:59
    bus_if.optiune_user = 3'b011;
    validate_low();
    push("stopw_arm.opt", S_OPT, 3);
    push_cnt("stopw_arm.cnt", 0);
    drain();
    validate_release();
    bus_if.switch = 1'b1;
    t = 0;
    for (int c = 0; c < 3605; c++) begin
      @(negedge clk);
      t = (t < 3599) ? t + 1 : 3599;
      push_cnt($sformatf("stopw%0d", c), t);
      drain();
    end

    // 6c: asynchronous reset mid-run clears outputs immediately
    bus_if.optiune_user = 3'b000;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    push("arst.valid", S_VALID, 0);
    push("arst.fsm_reset", S_FSMRST, 0);
    push("arst.opt", S_OPT, 0);
    push_cnt("arst.cnt", 0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
